// File: rtl/filter2d_engine.sv
// 3x3 signed-kernel convolution engine. Sweeps a frame in raster order,
// reading nine neighbours per output pixel from a synchronous single-port
// frame buffer. Neighbours outside the image count as zero.
//
// state | meaning
// IDLE  | waiting for start; kernel latched on accept
// READ  | nine tap cycles (k=0..8), reads issued for in-image neighbours
// ACC   | last tap product folded into the accumulator
// OUT   | scaled/clamped pixel registered out, coordinates advanced
// FIN   | frame finished; done pulse raised, busy dropped
module filter2d_engine #(
  parameter int IMG_W = 256,
  parameter int IMG_H = 256,
  parameter int AW    = 16,
  parameter int SHIFT = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [71:0]   i_kernel,
  output logic          mem_rd,
  output logic [AW-1:0] rd_addr,
  input  logic [7:0]    rd_data,
  output logic          o_strb,
  output logic [7:0]    o_data,
  output logic [7:0]    o_x,
  output logic [7:0]    o_y,
  output logic          busy,
  output logic          done,
  output logic          overrun
);

  typedef enum logic [2:0] {IDLE, READ, ACC, OUT, FIN} state_t;

  localparam logic [7:0] X_LAST = 8'(IMG_W - 1);
  localparam logic [7:0] Y_LAST = 8'(IMG_H - 1);

  state_t              state_q, state_d;
  logic [3:0]          k_q;
  logic [7:0]          x_q, y_q;
  logic signed [19:0]  acc_q;
  logic signed [7:0]   coef_q [9];
  logic                tap_v_q;
  logic [3:0]          tap_k_q;

  logic                col_lo, col_hi, row_lo, row_hi, tap_ok, last_pix;
  logic [AW-1:0]       pix_addr, row_off, col_off;
  logic signed [16:0]  prod;
  logic signed [19:0]  acc_sh;
  logic [7:0]          pix_clamp;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = READ;
      READ: if (k_q == 4'd8) state_d = ACC;
      ACC:  state_d = OUT;
      OUT:  state_d = last_pix ? FIN : READ;
      FIN:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Tap geometry: k = (dy+1)*3 + (dx+1); read only neighbours inside the image
  always_comb begin
    col_lo   = (k_q == 4'd0) || (k_q == 4'd3) || (k_q == 4'd6);
    col_hi   = (k_q == 4'd2) || (k_q == 4'd5) || (k_q == 4'd8);
    row_lo   = (k_q < 4'd3);
    row_hi   = (k_q >= 4'd6);
    tap_ok   = !(col_lo && x_q == 8'd0) && !(col_hi && x_q == X_LAST) &&
               !(row_lo && y_q == 8'd0) && !(row_hi && y_q == Y_LAST);
    last_pix = (x_q == X_LAST) && (y_q == Y_LAST);
    pix_addr = AW'(y_q) * AW'(IMG_W) + AW'(x_q);
    row_off  = row_lo ? (~AW'(IMG_W) + AW'(1)) : (row_hi ? AW'(IMG_W) : '0);
    col_off  = col_lo ? '1 : (col_hi ? AW'(1) : '0);
    mem_rd   = (state_q == READ) && tap_ok;
    rd_addr  = mem_rd ? (pix_addr + row_off + col_off) : '0;
  end

  // MAC product and output scaling/clamp
  always_comb begin
    prod      = $signed({1'b0, rd_data}) * coef_q[tap_k_q];
    acc_sh    = acc_q >>> SHIFT;
    pix_clamp = acc_sh[19] ? 8'd0 : ((acc_sh > 20'sd255) ? 8'd255 : acc_sh[7:0]);
  end

  // Kernel is captured only when a frame is accepted
  always_ff @(posedge clk) begin
    if (state_q == IDLE && start) begin
      for (int i = 0; i < 9; i++) coef_q[i] <= i_kernel[8*i +: 8];
    end
  end

  // Sweep datapath, tap pipeline and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      k_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      acc_q   <= '0;
      tap_v_q <= 1'b0;
      tap_k_q <= '0;
      o_strb  <= 1'b0;
      o_data  <= '0;
      o_x     <= '0;
      o_y     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      tap_v_q <= mem_rd;
      tap_k_q <= k_q;
      o_strb  <= 1'b0;
      done    <= 1'b0;
      overrun <= start && (state_q != IDLE);
      if (tap_v_q) acc_q <= acc_q + {{3{prod[16]}}, prod};
      case (state_q)
        IDLE: begin
          if (start) begin
            x_q   <= '0;
            y_q   <= '0;
            k_q   <= '0;
            acc_q <= '0;
            busy  <= 1'b1;
          end
        end
        READ: k_q <= k_q + 4'd1;
        OUT: begin
          o_strb <= 1'b1;
          o_data <= pix_clamp;
          o_x    <= x_q;
          o_y    <= y_q;
          acc_q  <= '0;
          k_q    <= '0;
          if (x_q == X_LAST) begin
            x_q <= '0;
            y_q <= y_q + 8'd1;
          end else begin
            x_q <= x_q + 8'd1;
          end
        end
        FIN: begin
          busy <= 1'b0;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
